// File: rtl/gcd_pkg.sv
// Shared types and defaults for the iterative GCD engine.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_datapath.sv
// GCD operand registers, comparator, subtractor and result register.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             capture_i,
  input  logic [WIDTH-1:0] a_in_i,
  input  logic [WIDTH-1:0] b_in_i,
  output logic             a_zero_o,
  output logic             b_zero_o,
  output logic             a_eq_b_o,
  output logic             a_gt_b_o,
  output logic [WIDTH-1:0] g_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;

  assign a_zero_o = (a_q == '0);
  assign b_zero_o = (b_q == '0);
  assign a_eq_b_o = (a_q == b_q);
  assign a_gt_b_o = (a_q > b_q);
  assign g_o      = g_q;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    g_d = g_q;
    if (load_i) begin
      a_d = a_in_i;
      b_d = b_in_i;
    end else if (step_i) begin
      // Always larger minus smaller, so the difference never wraps.
      if (a_gt_b_o) a_d = a_q - b_q;
      else          b_d = b_q - a_q;
    end
    if (capture_i) g_d = a_zero_o ? b_q : a_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      g_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      g_q <= g_d;
    end
  end

endmodule

// File: rtl/gcd.sv
// Iterative GCD accelerator: control FSM and output_valid handshake register.
module gcd
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             input_valid,
  input  logic             gcd_ack,
  output logic [WIDTH-1:0] G_out,
  output logic             output_valid
);

  gcd_state_t state_q, state_d;
  logic       valid_q, valid_d;
  logic       load, step, capture;
  logic       a_zero, b_zero, a_eq_b, a_gt_b;
  logic       finish;

  assign finish       = a_zero | b_zero | a_eq_b;
  assign output_valid = valid_q;

  gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .step_i    (step),
    .capture_i (capture),
    .a_in_i    (A_in),
    .b_in_i    (B_in),
    .a_zero_o  (a_zero),
    .b_zero_o  (b_zero),
    .a_eq_b_o  (a_eq_b),
    .a_gt_b_o  (a_gt_b),
    .g_o       (G_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (input_valid) state_d = CALC;
      CALC:    if (finish)      state_d = DONE;
      DONE:    if (gcd_ack)     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    step    = 1'b0;
    capture = 1'b0;
    valid_d = valid_q;
    case (state_q)
      IDLE: load = input_valid;
      CALC: begin
        if (finish) begin
          capture = 1'b1;
          valid_d = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    if (gcd_ack) valid_d = 1'b0;
      default: valid_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_gcd.sv
// Scoreboard bench for gcd: stimulus pushes expected result/latency, a monitor checks each rising output_valid.
module tb_gcd;

  logic       clk;
  logic       reset;
  logic [7:0] A_in;
  logic [7:0] B_in;
  logic       input_valid;
  logic       gcd_ack;
  logic [7:0] G_out;
  logic       output_valid;

  typedef struct {
    int g;
    int lat;
    int load_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  logic prev_ov = 1'b0;

  gcd #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .A_in         (A_in),
    .B_in         (B_in),
    .input_valid  (input_valid),
    .gcd_ack      (gcd_ack),
    .G_out        (G_out),
    .output_valid (output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising output_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset) begin
      prev_ov <= 1'b0;
    end else begin
      if (output_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got G_out=%0d, expected no result (cycle %0d)", G_out, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", int'(G_out), e.g);
          chk("latency", cyc - e.load_cyc, e.lat);
        end
      end
      prev_ov <= output_valid;
    end
  end

  task automatic start(input int a, input int b, input int g, input int lat);
    exp_t e;
    A_in        = 8'(a);
    B_in        = 8'(b);
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    e.g        = g;
    e.lat      = lat;
    e.load_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!output_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!output_valid) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got output_valid=0, expected 1 within 400 cycles", name);
    end
  endtask

  task automatic ack_and_check(input string name, input int g);
    gcd_ack = 1'b1;
    @(negedge clk);
    gcd_ack = 1'b0;
    chk({name, "_ov_after_ack"}, int'(output_valid), 0);
    chk({name, "_g_after_ack"}, int'(G_out), g);
  endtask

  task automatic run(input string name, input int a, input int b, input int g, input int lat);
    start(a, b, g, lat);
    wait_valid(name);
    ack_and_check(name, g);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    A_in        = '0;
    B_in        = '0;
    input_valid = 1'b0;
    gcd_ack     = 1'b0;
    #1;
    chk("reset_g", int'(G_out), 0);
    chk("reset_ov", int'(output_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ov", int'(output_valid), 0);

    // Ack while idle has no effect.
    gcd_ack = 1'b1;
    @(negedge clk);
    gcd_ack = 1'b0;
    chk("ack_idle_ov", int'(output_valid), 0);

    // Basic (21,18): held until ack, ignoring starts while in DONE.
    start(21, 18, 3, 7);
    wait_valid("basic");
    for (int i = 0; i < 3; i++) begin
      A_in        = 8'd48;
      B_in        = 8'd36;
      input_valid = (i == 1);
      @(negedge clk);
      chk("done_hold_ov", int'(output_valid), 1);
      chk("done_hold_g", int'(G_out), 3);
    end
    input_valid = 1'b0;
    ack_and_check("basic", 3);
    @(negedge clk);

    // Re-run with a busy start and an ack during CALC, both ignored.
    start(21, 18, 3, 7);
    @(negedge clk);
    A_in        = 8'd48;
    B_in        = 8'd36;
    input_valid = 1'b1;
    gcd_ack     = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    gcd_ack     = 1'b0;
    wait_valid("rerun");
    ack_and_check("rerun", 3);
    @(negedge clk);

    run("zero_a",  0,   5,   5, 1);
    run("zero_b",  7,   0,   7, 1);
    run("zero_ab", 0,   0,   0, 1);
    run("equal",   9,   9,   9, 1);
    run("w255_1",  255, 1,   1, 255);
    run("w1_255",  1,   255, 1, 255);
    run("b48_36",  48,  36,  12, 4);

    // Ack held throughout: output_valid lasts exactly one cycle.
    gcd_ack = 1'b1;
    start(7, 0, 7, 1);
    wait_valid("ack_held");
    @(negedge clk);
    chk("ack_held_ov", int'(output_valid), 0);
    gcd_ack = 1'b0;
    @(negedge clk);

    // Ack and start together in DONE: ack wins, operands not loaded.
    start(9, 9, 9, 1);
    wait_valid("ack_start");
    A_in        = 8'd48;
    B_in        = 8'd36;
    input_valid = 1'b1;
    gcd_ack     = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    gcd_ack     = 1'b0;
    chk("ack_start_ov", int'(output_valid), 0);
    repeat (10) @(negedge clk);
    chk("ack_start_no_run_ov", int'(output_valid), 0);
    chk("ack_start_g", int'(G_out), 9);

    // Reset during a long computation abandons it.
    start(255, 1, 1, 255);
    repeat (50) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_g", int'(G_out), 0);
    chk("midreset_ov", int'(output_valid), 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run("after_reset", 12, 8, 4, 3);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gcd.md
# gcd

Iterative greatest-common-divisor engine for unsigned operands, using one subtract-and-compare step per clock. It accepts an operand pair on a single-cycle `input_valid` strobe and computes the GCD by repeated subtraction. The result is presented with a level `output_valid` that is held until the consumer acknowledges it. It is a standalone accelerator slave between an operand producer and a result consumer.

## Interface
- `WIDTH`, default 8: operand and result width in bits.

- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `A_in`  in  WIDTH: operand A, unsigned; sampled only on acceptance.
- `B_in`  in  WIDTH: operand B, unsigned; sampled only on acceptance.
- `input_valid`  in  1: start request; sampled each rising edge.
- `gcd_ack`  in  1: consumer acknowledge of the result; sampled each rising edge.
- `G_out`  out  WIDTH: result register.
- `output_valid`  out  1: high while `G_out` holds an unacknowledged result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `input_valid`=1 at an edge loads A←`A_in` and B←`B_in`, then goes to CALC.
  - Otherwise the block stays in IDLE.
- CALC, one action per edge, first match wins:
  - A==0: `G_out`←B, go to DONE.
  - B==0: `G_out`←A, go to DONE.
  - A==B: `G_out`←A, go to DONE.
  - A>B: A←A−B.
  - Else: B←B−A.
- Entering DONE sets `output_valid`←1.
- DONE:
  - `gcd_ack`=1 at an edge clears `output_valid` and returns to IDLE.
  - Otherwise the block holds with `output_valid`=1 and `G_out` stable.
- GCD(0,0)=0. GCD(x,0)=GCD(0,x)=x.
- Arithmetic: unsigned, WIDTH bits. Subtraction is always larger minus smaller, so no underflow or wrap is possible.
- `G_out` keeps the last result after acknowledgement until the next result is written.

## Timing
- Reset values, effective immediately and asynchronously: state IDLE, `G_out`=0, `output_valid`=0, A=B=0.
- Reset asserted mid-computation or in DONE: the operation is abandoned and no result is produced.
- Latency: if the load is at edge k, `output_valid` rises after edge k+S+1, where S is the number of subtraction steps.
  - Example: (21,18) gives S=6, so `output_valid` rises after edge k+7.
  - Worst case for WIDTH=8 is (255,1) or (1,255): S=254, latency 255 cycles.
  - A zero operand gives latency 1.
- `input_valid` is ignored in CALC and DONE; there is no queueing and no error flag.
- `gcd_ack` is ignored outside DONE.
- `gcd_ack` held high continuously acks in the first DONE cycle, so `output_valid` is high for exactly one cycle.
- `gcd_ack` and `input_valid` both high in DONE: the ack is processed and `input_valid` is ignored. A new start is accepted from IDLE on a later edge only.
- Throughput: at most one operation in flight. Minimum back-to-back spacing is latency + 1 ack cycle + 1 IDLE accept cycle.

## Structure
- Package `gcd_pkg` holds:
  - the state enum type (IDLE, CALC, DONE);
  - the default WIDTH constant.
- One sub-module, `gcd_datapath`, holds:
  - the A/B registers;
  - the comparator (A==B, A>B, zero detects);
  - the subtractor;
  - the `G_out` register.
- It exposes status flags to the FSM and takes load/step/capture controls.
- The FSM and the `output_valid` register live in the top module `gcd`.

## Test plan
- Reset: with `reset`=0, outputs read `G_out`=0 and `output_valid`=0. Releasing reset leaves the block in IDLE, with no activity until a start.
- Basic case (21,18): `input_valid` pulse → `output_valid` rises 7 cycles after the load edge with `G_out`=3 and stays high until `gcd_ack`. After the ack edge, `output_valid`=0 and `G_out` still reads 3.
- Re-run: the same operands after the ack give `G_out`=3 with identical latency. Additionally, a start of (48,36) issued while busy is ignored, and the result is still 3.
- Corners:
  - (0,5) → 5 after 1 cycle;
  - (7,0) → 7;
  - (0,0) → 0;
  - (9,9) → 9 after 1 cycle;
  - (255,1) → 1 after 255 cycles;
  - (1,255) → 1.
- Handshake edges:
  - `gcd_ack` held high throughout → `output_valid` high for exactly one cycle.
  - `gcd_ack` asserted in IDLE or CALC → no effect.
  - Simultaneous `gcd_ack` and `input_valid` in DONE → return to IDLE, and the new operands are not loaded.
- Reset mid-operation: assert `reset` during CALC of (255,1) → immediate IDLE with outputs 0. A fresh (12,8) then yields 4.
